frv_mmio_initiator: RTL

//  Core-side MMIO bus initiator. Accepts single load/store requests from the
//  LSU, decodes them against the MMIO window, and issues one-cycle mmio_en

---
 rtl/frv_mmio_initiator_pkg.sv | 27 ++
 rtl/frv_mmio_initiator_if.sv | 49 ++++
 rtl/frv_mmio_rsp_buf.sv | 60 ++++++
 rtl/frv_mmio_initiator.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/frv_mmio_initiator_pkg.sv
// ----------------------------------------------------------------------------
// frv_mmio_initiator_pkg
//   Shared definitions for the core-side MMIO initiator and its responders:
//   the 2-bit FSM state encoding, the default MMIO window and a decode helper.
//   Configuration macro honoured by the initiator: FRV_MMIO_ALIGN_CHECK_EN.
// ----------------------------------------------------------------------------
package frv_mmio_initiator_pkg;

    // Default MMIO window, also used by the responders.
    localparam logic [31:0] MMIO_BASE_ADDR_DFLT = 32'h0000_1000;
    localparam logic [31:0] MMIO_BASE_MASK_DFLT = 32'hFFFF_F000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } frv_mmio_state_e;

    // Address falls inside the MMIO window.
    function automatic logic mmio_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/frv_mmio_initiator_if.sv
// ----------------------------------------------------------------------------
// frv_mmio_initiator_if
//   Bundles the LSU request/response handshake and the MMIO bus signals.
//   modport master : the initiator (accepts LSU requests, drives the MMIO bus)
//   modport slave  : the environment (LSU plus MMIO responders)
// ----------------------------------------------------------------------------
interface frv_mmio_initiator_if;

    // LSU request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [3:0]  req_strb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // LSU response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    // MMIO bus
    logic        mmio_en;
    logic        mmio_wen;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        mmio_error;

    modport master (
        input  req_valid, req_wen, req_strb, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready,
        output mmio_en, mmio_wen, mmio_addr, mmio_wdata,
        input  mmio_rdata, mmio_error
    );

    modport slave (
        output req_valid, req_wen, req_strb, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready,
        input  mmio_en, mmio_wen, mmio_addr, mmio_wdata,
        output mmio_rdata, mmio_error
    );

endinterface

// File: rtl/frv_mmio_rsp_buf.sv
// ----------------------------------------------------------------------------
// frv_mmio_rsp_buf
//   Single-entry response register. A load pulse captures rdata/error and
//   raises valid; the entry then holds stable until the valid&&ready
//   handshake clears it.
// Ports:
//   g_clk, g_resetn      clock, synchronous active-low reset
//   load_i               capture rdata_i/error_i this cycle
//   rdata_i, error_i     response payload to capture
//   ready_i              consumer accepts the response
//   valid_o, rdata_o,    registered response
//   error_o
// ----------------------------------------------------------------------------
module frv_mmio_rsp_buf (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        load_i,
    input  logic [31:0] rdata_i,
    input  logic        error_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        error_o
);

    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        error_d = error_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            rdata_d = rdata_i;
            error_d = error_i;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign valid_o = valid_q;
    assign rdata_o = rdata_q;
    assign error_o = error_q;

endmodule

// File: rtl/frv_mmio_initiator.sv
// ----------------------------------------------------------------------------
// frv_mmio_initiator
//   Core-side MMIO bus initiator. Accepts one LSU load/store at a time,
//   decodes it against the MMIO window, issues a single-cycle mmio_en access
//   to a fixed-latency responder and returns rdata/error through a
//   single-entry response buffer with valid/ready backpressure.
// Parameters:
//   MMIO_BASE_ADDR  base of the MMIO window
//   MMIO_BASE_MASK  address bits compared against the base
//   RSP_LATENCY     cycles from the mmio_en cycle to valid rdata/error (>=1)
// Ports:
//   g_clk, g_resetn clock, synchronous active-low reset
//   bus             frv_mmio_initiator_if.master (LSU req/rsp + MMIO bus)
// Configuration:
//   FRV_MMIO_ALIGN_CHECK_EN defined   : misaligned hits and partial-strobe
//                                       stores fault like a decode miss
//   FRV_MMIO_ALIGN_CHECK_EN undefined : address forced word-aligned and
//                                       stores always write the full word
// ----------------------------------------------------------------------------
module frv_mmio_initiator
    import frv_mmio_initiator_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE_ADDR = MMIO_BASE_ADDR_DFLT,
    parameter logic [31:0] MMIO_BASE_MASK = MMIO_BASE_MASK_DFLT,
    parameter int unsigned RSP_LATENCY    = 1
) (
    input  logic                        g_clk,
    input  logic                        g_resetn,
    frv_mmio_initiator_if.master        bus
);

    localparam int unsigned     CNT_W    = $clog2(RSP_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RSP_LATENCY - 1);

    frv_mmio_state_e    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               req_ready;
    logic               mmio_en;
    logic               hit;
    logic               fault;
    logic [31:0]        acc_addr;

    logic               buf_load;
    logic [31:0]        buf_rdata;
    logic               buf_error;
    logic               rsp_valid;

    assign hit = mmio_hit(bus.req_addr, MMIO_BASE_ADDR, MMIO_BASE_MASK);

`ifdef FRV_MMIO_ALIGN_CHECK_EN
    assign fault    = hit && ((bus.req_addr[1:0] != 2'b00) ||
                              (bus.req_wen && (bus.req_strb != 4'hF)));
    assign acc_addr = bus.req_addr;
`else
    // Byte strobes are ignored here: every store writes the full word.
    logic unused_strb;
    assign unused_strb = ^bus.req_strb;
    assign fault       = 1'b0;
    assign acc_addr    = {bus.req_addr[31:2], 2'b00};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        req_ready = 1'b0;
        mmio_en   = 1'b0;
        buf_load  = 1'b0;
        buf_rdata = '0;
        buf_error = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (hit && !fault) begin
                        addr_d  = acc_addr;
                        wen_d   = bus.req_wen;
                        wdata_d = bus.req_wdata;
                        state_d = ST_ISSUE;
                    end else begin
                        // Decode miss or fault: answer directly, no bus cycle.
                        buf_load  = 1'b1;
                        buf_error = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                mmio_en = 1'b1;
                cnt_d   = CNT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    buf_load  = 1'b1;
                    buf_rdata = wen_q ? '0 : bus.mmio_rdata;
                    buf_error = bus.mmio_error;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid && bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
        end
    end

    frv_mmio_rsp_buf u_rsp_buf (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .load_i   (buf_load),
        .rdata_i  (buf_rdata),
        .error_i  (buf_error),
        .ready_i  (bus.rsp_ready),
        .valid_o  (rsp_valid),
        .rdata_o  (bus.rsp_rdata),
        .error_o  (bus.rsp_error)
    );

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.mmio_en    = mmio_en;
    assign bus.mmio_wen   = wen_q;
    assign bus.mmio_addr  = addr_q;
    assign bus.mmio_wdata = wdata_q;

endmodule
